// File: rtl/data_mem_responder.sv
// Multi-cycle data memory slave: valid/ready request, wait states, valid/ready response.
// Define DATA_MEM_ALIGN_CHECK_EN to flag and suppress misaligned half/word accesses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [1:0]  Req_Width,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_WData,
  output logic        Resp_Valid,
  input  logic        Resp_Ready,
  output logic [31:0] Resp_RData,
  output logic        Resp_Err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_COMMIT,
    S_RESP
  } state_t;

  state_t state;
  logic [3:0] cnt;

  logic          wr_q;
  logic [1:0]    width_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_ext;
  logic [31:0]   lane;
  logic [3:0]    be;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic          misal;
  logic          we;
  logic          unused_addr;

  assign unused_addr = ^Req_Addr[31:AW+2];

  assign idx     = addr_q[AW+1:2];
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    be     = 4'b1111;
    lane   = wdata_q;
    rd_ext = rd_word;
    case (width_q)
      2'b01: begin
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        lane   = {2{wdata_q[15:0]}};
        rd_ext = {{16{rd_half[15]}}, rd_half};
      end
      2'b10: begin
        be     = 4'b0001 << addr_q[1:0];
        lane   = {4{wdata_q[7:0]}};
        rd_ext = {{24{rd_byte[7]}}, rd_byte};
      end
      default: begin
        be     = 4'b1111;
        lane   = wdata_q;
        rd_ext = rd_word;
      end
    endcase
  end

`ifdef DATA_MEM_ALIGN_CHECK_EN
  always_comb begin
    misal = 1'b0;
    case (width_q)
      2'b01:   misal = addr_q[0];
      2'b10:   misal = 1'b0;
      default: misal = (addr_q[1:0] != 2'b00);
    endcase
  end
`else
  assign misal = 1'b0;
`endif

  // Reset gates the commit so an in-flight store is dropped.
  assign we = Reset && (state == S_COMMIT) && wr_q && !misal;

  always_ff @(posedge Clock) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= lane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      Req_Ready  <= 1'b0;
      Resp_Valid <= 1'b0;
      Resp_RData <= '0;
      Resp_Err   <= 1'b0;
      wr_q       <= 1'b0;
      width_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Req_Valid && Req_Ready) begin
            wr_q      <= Req_Write;
            width_q   <= Req_Width;
            addr_q    <= Req_Addr[AW+1:0];
            wdata_q   <= Req_WData;
            Req_Ready <= 1'b0;
            cnt       <= '0;
            state     <= (WAIT_CYCLES > 0) ? S_WAIT : S_COMMIT;
          end else begin
            Req_Ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == WC) state <= S_COMMIT;
          else cnt <= cnt + 4'd1;
        end
        S_COMMIT: begin
          Resp_RData <= (wr_q || misal) ? 32'd0 : rd_ext;
          Resp_Err   <= misal;
          Resp_Valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (Resp_Ready) begin
            Resp_Valid <= 1'b0;
            Req_Ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (WAIT_CYCLES=2).
// Align-check expectations follow DATA_MEM_ALIGN_CHECK_EN.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_width;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .Clock(clk),
    .Reset(rst_n),
    .Req_Valid(req_valid),
    .Req_Ready(req_ready),
    .Req_Write(req_write),
    .Req_Width(req_width),
    .Req_Addr(req_addr),
    .Req_WData(req_wdata),
    .Resp_Valid(resp_valid),
    .Resp_Ready(resp_ready),
    .Resp_RData(resp_rdata),
    .Resp_Err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam logic        AL_ERR  = 1'b1;
  localparam logic [31:0] AL_WORD = 32'hCAFEF00D;
  localparam logic [31:0] AL_MIS  = 32'h0;
`else
  localparam logic        AL_ERR  = 1'b0;
  localparam logic [31:0] AL_WORD = 32'hCAFEABCD;
  localparam logic [31:0] AL_MIS  = 32'hCAFEABCD;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic send(input logic w, input logic [1:0] wid,
                      input logic [31:0] a, input logic [31:0] d);
    bit ok;
    logic r;
    ok = 1'b0;
    req_write = w;
    req_width = wid;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      r = req_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    acc_cyc = cyc;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout addr=%h", a);
    end
  endtask

  task automatic wait_resp(output logic [31:0] rd, output logic er,
                           output int lat, output bit to);
    to = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (resp_valid) begin
        to = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    rd  = resp_rdata;
    er  = resp_err;
    lat = cyc - acc_cyc;
    if (!to && resp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_width = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
        errors++;
        $display("FAIL reset_hold rdy=%b vld=%b rdata=%h want 0 0 0",
                 req_ready, resp_valid, resp_rdata);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_release rdy=%b vld=%b rdata=%h want 1 0 0",
               req_ready, resp_valid, resp_rdata);
    end
  endtask

  task automatic test_word;
    logic [31:0] rd;
    logic er;
    int lat;
    bit to;
    exp_t ex;
    q.push_back('{d: 32'd0, e: 1'b0});
    send(1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
    wait_resp(rd, er, lat, to);
    ex = q.pop_front();
    checks++;
    if (to || rd !== ex.d || er !== ex.e || lat !== 4) begin
      errors++;
      $display("FAIL word_store got %h/%b lat %0d to %0d want %h/%b lat 4",
               rd, er, lat, to, ex.d, ex.e);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_return got %b want 1", req_ready);
    end
    q.push_back('{d: 32'hDEADBEEF, e: 1'b0});
    send(1'b0, 2'b00, 32'h10, 32'h0);
    wait_resp(rd, er, lat, to);
    ex = q.pop_front();
    checks++;
    if (to || rd !== ex.d || er !== ex.e || lat !== 4) begin
      errors++;
      $display("FAIL word_load got %h/%b lat %0d to %0d want %h/%b lat 4",
               rd, er, lat, to, ex.d, ex.e);
    end
  endtask

  task automatic test_byte_half;
    logic [31:0] rd;
    logic er;
    int lat;
    bit to;
    exp_t ex;
    logic        tw [7];
    logic [1:0]  tz [7];
    logic [31:0] ta [7];
    logic [31:0] td [7];
    logic [31:0] te [7];
    tw = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tz = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b10};
    ta = '{32'h10, 32'h13, 32'h13, 32'h10, 32'h10, 32'h12, 32'h11};
    td = '{32'h11223344, 32'h80, 0, 0, 0, 0, 0};
    te = '{32'h0, 32'h0, 32'hFFFFFF80, 32'h80223344,
           32'h00003344, 32'hFFFF8022, 32'h00000033};
    for (int i = 0; i < 7; i++) begin
      q.push_back('{d: te[i], e: 1'b0});
      send(tw[i], tz[i], ta[i], td[i]);
      wait_resp(rd, er, lat, to);
      ex = q.pop_front();
      checks++;
      if (to || rd !== ex.d || er !== ex.e || lat !== 4) begin
        errors++;
        $display("FAIL byte_half[%0d] got %h/%b lat %0d want %h/%b lat 4",
                 i, rd, er, lat, ex.d, ex.e);
      end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] rd;
    logic er;
    int lat;
    bit to;
    exp_t ex;
    logic [31:0] wa [2];
    wa = '{32'h00001010, 32'hFFFFF010};
    for (int i = 0; i < 2; i++) begin
      q.push_back('{d: 32'h80223344, e: 1'b0});
      send(1'b0, 2'b00, wa[i], 32'h0);
      wait_resp(rd, er, lat, to);
      ex = q.pop_front();
      checks++;
      if (to || rd !== ex.d || er !== ex.e) begin
        errors++;
        $display("FAIL wrap[%0d] got %h/%b want %h/%b", i, rd, er, ex.d, ex.e);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd;
    logic er;
    int lat;
    bit to;
    exp_t ex;
    bit seen;
    resp_ready = 1'b0;
    q.push_back('{d: 32'h80223344, e: 1'b0});
    send(1'b0, 2'b00, 32'h10, 32'h0);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_first_resp timeout");
    end
    q.push_back('{d: 32'hFFFFFF80, e: 1'b0});
    req_write = 1'b0;
    req_width = 2'b10;
    req_addr  = 32'h13;
    req_valid = 1'b1;
    ex = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== ex.d || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] vld=%b rdata=%h rdy=%b want 1 %h 0",
                 i, resp_valid, resp_rdata, req_ready, ex.d);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_handshake vld=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept rdy=%b want 0", req_ready);
    end
    wait_resp(rd, er, lat, to);
    ex = q.pop_front();
    checks++;
    if (to || rd !== ex.d || er !== ex.e || lat !== 4) begin
      errors++;
      $display("FAIL bp_second got %h/%b lat %0d want %h/%b lat 4",
               rd, er, lat, ex.d, ex.e);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd;
    logic er;
    int lat;
    bit to;
    exp_t ex;
    bit bad;
    q.push_back('{d: 32'h0, e: 1'b0});
    send(1'b1, 2'b00, 32'h20, 32'hCAFEF00D);
    wait_resp(rd, er, lat, to);
    ex = q.pop_front();
    checks++;
    if (to || rd !== ex.d || er !== ex.e) begin
      errors++;
      $display("FAIL abort_setup got %h/%b want %h/%b", rd, er, ex.d, ex.e);
    end
    send(1'b1, 2'b00, 32'h20, 32'h12345678);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid !== 1'b0) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_no_resp saw Resp_Valid=1 want 0");
    end
    q.push_back('{d: 32'hCAFEF00D, e: 1'b0});
    send(1'b0, 2'b00, 32'h20, 32'h0);
    wait_resp(rd, er, lat, to);
    ex = q.pop_front();
    checks++;
    if (to || rd !== ex.d || er !== ex.e) begin
      errors++;
      $display("FAIL abort_contents got %h/%b want %h/%b", rd, er, ex.d, ex.e);
    end
  endtask

  task automatic test_align;
    logic [31:0] rd;
    logic er;
    int lat;
    bit to;
    exp_t ex;
    logic        tw [3];
    logic [1:0]  tz [3];
    logic [31:0] ta [3];
    logic [31:0] td [3];
    logic [31:0] te [3];
    logic        tr [3];
    tw = '{1'b1, 1'b0, 1'b0};
    tz = '{2'b01, 2'b00, 2'b11};
    ta = '{32'h21, 32'h20, 32'h22};
    td = '{32'h0000ABCD, 0, 0};
    te = '{32'h0, AL_WORD, AL_MIS};
    tr = '{AL_ERR, 1'b0, AL_ERR};
    for (int i = 0; i < 3; i++) begin
      q.push_back('{d: te[i], e: tr[i]});
      send(tw[i], tz[i], ta[i], td[i]);
      wait_resp(rd, er, lat, to);
      ex = q.pop_front();
      checks++;
      if (to || rd !== ex.d || er !== ex.e || lat !== 4) begin
        errors++;
        $display("FAIL align[%0d] got %h/%b lat %0d want %h/%b lat 4",
                 i, rd, er, lat, ex.d, ex.e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_wrap();
    test_backpressure();
    test_reset_abort();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
